// File: rtl/fetch_unit_pkg.sv
// Shared types and default parameters for the instruction fetch stage.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

  localparam int unsigned DefAw      = 16;
  localparam int unsigned DefDw      = 16;
  localparam int unsigned DefDepth   = 2;
  localparam logic [15:0] DefResetPc = 16'h0000;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO holding {pc, instruction} pairs; flush beats same-cycle push or pop.
module fetch_unit_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A full FIFO may still accept a write when the head leaves in the same cycle.
  assign wr_en = push && !flush && (!full || pop);
  assign rd_en = pop && !flush && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding memory reads and
// buffers returned words for the decoder.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned   AW       = DefAw,
  parameter int unsigned   DW       = DefDw,
  parameter int unsigned   DEPTH    = DefDepth,
  parameter logic [AW-1:0] RESET_PC = AW'(DefResetPc)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          fetch_en,
  input  logic          jump_en,
  input  logic [AW-1:0] jump_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          busy
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned FW   = AW + DW;

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;

  logic            fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [FW-1:0]   fifo_dout;
  logic [CntW-1:0] fifo_count, count_after;
  logic [AW-1:0]   pc_inc;

  // The jump cycle never completes a handshake, so the flush cannot race a pop.
  assign instr_valid = !fifo_empty && !jump_en;
  assign fifo_pop    = instr_valid && instr_ready;
  assign instr_pc    = fifo_dout[FW-1:DW];
  assign instr       = fifo_dout[DW-1:0];
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign busy        = mem_req_q || (state_q == StDrop);

  assign pc_inc      = fetch_pc_q + AW'(1);
  assign count_after = fifo_count + CntW'(1) - CntW'(fifo_pop);

  fetch_unit_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     ({fetch_pc_q, mem_rdata}),
    .pop     (fifo_pop),
    .flush   (jump_en),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fifo_push  = 1'b0;

    case (state_q)
      StIdle: begin
        if (fetch_en && !jump_en && !fifo_full) begin
          state_d    = StReq;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end
      StReq: begin
        if (jump_en) begin
          // A request cannot be withdrawn; wait out the ack in StDrop unless it lands now.
          if (mem_ack) begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
          end else begin
            state_d = StDrop;
          end
        end else if (mem_ack) begin
          fifo_push  = 1'b1;
          fetch_pc_d = pc_inc;
          if (fetch_en && (count_after < CntW'(DEPTH))) begin
            mem_addr_d = pc_inc;
          end else begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
          end
        end
      end
      StDrop: begin
        if (mem_ack) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase

    if (jump_en) fetch_pc_d = jump_addr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder, reference instruction stream
// queue, and a monitor that checks every decoder handshake against it.
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en, jump_en, instr_ready;
  logic [15:0] jump_addr;
  logic        mem_req, instr_valid, busy;
  logic [15:0] mem_addr, instr, instr_pc;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;

  logic        w_req, w_valid, w_busy;
  logic [15:0] w_addr, w_instr, w_pc;
  logic        w_ack = 1'b0;
  logic [15:0] w_rdata = '0;

  int unsigned wait_cfg = 0;
  int unsigned rw = 0;
  int unsigned mcnt = 0;
  bit          rand_wait = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          ack_cnt = 0;
  exp_t        exp_q[$];
  exp_t        w_seen[$];
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [15:0] prev_addr = '0;

  always #5 clk = ~clk;

  fetch_unit #(.AW(16), .DW(16), .DEPTH(2), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .jump_en(jump_en),
    .jump_addr(jump_addr), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .busy(busy)
  );

  fetch_unit #(.AW(16), .DW(16), .DEPTH(2), .RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .fetch_en(1'b1), .jump_en(1'b0),
    .jump_addr(16'h0000), .mem_req(w_req), .mem_addr(w_addr), .mem_ack(w_ack),
    .mem_rdata(w_rdata), .instr_valid(w_valid), .instr_ready(1'b1),
    .instr(w_instr), .instr_pc(w_pc), .busy(w_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order model: sequential words from a start PC, data = pc ^ A5A5.
  task automatic restart_stream(input logic [15:0] start);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back({start + 16'(i), (start + 16'(i)) ^ 16'hA5A5});
  endtask

  // Memory with configurable wait; acks one cycle, then waits for the next request.
  always @(posedge clk) begin
    if (mem_ack) begin
      mem_ack <= 1'b0;
      mcnt    <= 0;
    end else if (mem_req) begin
      if (mcnt >= (rand_wait ? rw : wait_cfg)) begin
        mem_ack   <= 1'b1;
        mem_rdata <= mem_addr ^ 16'hA5A5;
        rw        <= $urandom_range(0, 3);
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  always @(posedge clk) begin
    w_ack   <= w_req && !w_ack;
    w_rdata <= w_addr ^ 16'hA5A5;
  end

  // Monitor: scoreboard pops on every handshake, protocol checks on the memory side.
  always @(negedge clk) begin
    if (reset_n) begin
      if (jump_en) chk("valid_in_jump", 32'(instr_valid), 32'd0);
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("instr_pc", 32'(instr_pc), 32'(e.pc));
          chk("instr", 32'(instr), 32'(e.data));
          if (exp_q.size() < 4) begin
            exp_t l;
            l = exp_q[exp_q.size() - 1];
            exp_q.push_back({l.pc + 16'd1, (l.pc + 16'd1) ^ 16'hA5A5});
          end
        end
      end
      if (prev_req && !prev_ack && mem_req) chk("mem_addr_stable", 32'(mem_addr), 32'(prev_addr));
      if (mem_req && mem_ack) ack_cnt++;
      if (w_valid && w_seen.size() < 3) w_seen.push_back({w_pc, w_instr});
    end
    prev_req  <= mem_req;
    prev_ack  <= mem_ack;
    prev_addr <= mem_addr;
  end

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'h0000);
    chk("rst_instr_pc", 32'(instr_pc), 32'h0000);
    chk("rst_busy", 32'(busy), 32'd0);
    restart_stream(16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic pulse_jump(input logic [15:0] addr);
    jump_en   = 1'b1;
    jump_addr = addr;
    restart_stream(addr);
    @(posedge clk);
    #1;
    jump_en = 1'b0;
  endtask

  initial begin
    int   drops;
    bit   found;
    reset_n     = 1'b1;
    fetch_en    = 1'b1;
    jump_en     = 1'b0;
    jump_addr   = '0;
    instr_ready = 1'b1;
    #1;

    // Zero-wait memory: latency from reset release and continuous requests.
    do_reset();
    repeat (2) @(posedge clk);
    #1 chk("latency_edge2_valid", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1 chk("latency_edge3_valid", 32'(instr_valid), 32'd1);
    drops = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (!mem_req) drops++;
    end
    chk("mem_req_never_drops", 32'(drops), 32'd0);

    // Stalled decoder: only as many requests as the FIFO can hold.
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    wait_cfg    = 3;
    do_reset();
    ack_cnt = 0;
    repeat (30) @(posedge clk);
    #1;
    chk("stall_ack_count", 32'(ack_cnt), 32'd2);
    chk("stall_no_req", 32'(mem_req), 32'd0);
    chk("stall_valid", 32'(instr_valid), 32'd1);
    chk("stall_instr", 32'(instr), 32'h0000A5A5);
    chk("stall_pc", 32'(instr_pc), 32'd0);
    instr_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk);
      #1 if (mem_req) found = 1'b1;
    end
    chk("resume_req_seen", 32'(found), 32'd1);
    chk("resume_addr", 32'(mem_addr), 32'd2);

    // Redirect while waiting on address 3.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1 if (mem_req && mem_addr == 16'd3 && !mem_ack) found = 1'b1;
    end
    chk("wait_addr3_seen", 32'(found), 32'd1);
    pulse_jump(16'h0040);
    chk("drop_busy", 32'(busy), 32'd1);
    chk("drop_fifo_empty", 32'(instr_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1 if (mem_req && mem_addr != 16'd3) found = 1'b1;
    end
    chk("jump_req_seen", 32'(found), 32'd1);
    chk("jump_mem_addr", 32'(mem_addr), 32'h0040);
    repeat (20) @(posedge clk);

    // Redirect in a cycle where a handshake would otherwise complete.
    wait_cfg = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1 if (instr_valid) found = 1'b1;
    end
    chk("handshake_seen", 32'(found), 32'd1);
    pulse_jump(16'h0100);
    repeat (10) @(posedge clk);

    // Reset in the middle of a request with an ack already on the way.
    wait_cfg = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1 if (mem_req && mem_ack) found = 1'b1;
    end
    chk("ack_pending_seen", 32'(found), 32'd1);
    do_reset();
    repeat (20) @(posedge clk);

    // Randomised traffic.
    rand_wait = 1'b1;
    repeat (1500) begin
      @(posedge clk);
      #1;
      fetch_en    = ($urandom_range(0, 7) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        jump_en   = 1'b1;
        jump_addr = 16'($urandom);
        restart_stream(jump_addr);
      end else begin
        jump_en = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    jump_en  = 1'b0;
    fetch_en = 1'b0;
    repeat (20) @(posedge clk);

    chk("wrap_count", 32'(w_seen.size()), 32'd3);
    if (w_seen.size() == 3) begin
      chk("wrap_pc0", 32'(w_seen[0].pc), 32'h0000FFFF);
      chk("wrap_pc1", 32'(w_seen[1].pc), 32'h00000000);
      chk("wrap_pc2", 32'(w_seen[2].pc), 32'h00000001);
      chk("wrap_data0", 32'(w_seen[0].data), 32'h00005A5A);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
